alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_if.sv | 29 ++
 rtl/alu_ctrl.sv | 118 +++++++++++
 tb/tb_alu_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Request handshake bundle between a host and alu_ctrl.
// ALU_CTRL_IMM_EN adds the immediate operand fields.
interface alu_ctrl_if #(
`ifdef ALU_CTRL_IMM_EN
    parameter int unsigned DATA_W = 16,
`endif
    parameter int unsigned REG_AW = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_op;
    logic [REG_AW-1:0] req_rd;
    logic [REG_AW-1:0] req_rs;
    logic              req_wb;
`ifdef ALU_CTRL_IMM_EN
    logic [DATA_W-1:0] req_imm;
    logic              req_imm_sel;

    modport master (output req_valid, req_op, req_rd, req_rs, req_wb, req_imm, req_imm_sel,
                    input  req_ready);
    modport slave  (input  req_valid, req_op, req_rd, req_rs, req_wb, req_imm, req_imm_sel,
                    output req_ready);
`else
    modport master (output req_valid, req_op, req_rd, req_rs, req_wb,
                    input  req_ready);
    modport slave  (input  req_valid, req_op, req_rd, req_rs, req_wb,
                    output req_ready);
`endif
endinterface

// File: rtl/alu_ctrl.sv
// Register-file front end sequencing an external combinational ALU: IDLE/READ/EXEC/WB.
// Optional immediate operand on the B side when ALU_CTRL_IMM_EN is defined.
module alu_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    alu_ctrl_if.slave         req,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        flags_q,
    output logic              done,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int unsigned RF_DEPTH = 1 << REG_AW;
    localparam int unsigned OP_W     = 8;
    localparam int unsigned FLAG_W   = 5;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_q;
    logic              wb_q;
    logic [DATA_W-1:0] src_b;
    logic              accept;
`ifdef ALU_CTRL_IMM_EN
    logic [DATA_W-1:0] imm_q;
    logic              imm_sel_q;

    assign src_b = imm_sel_q ? imm_q : rf[rs_q];
`else
    assign src_b = rf[rs_q];
`endif

    // A pending host load blocks acceptance so load always wins in IDLE.
    assign req.req_ready = (state == IDLE) && !ld_en;
    assign accept        = req.req_valid && req.req_ready;
    assign dbg_data      = rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            rf      <= '{default: '0};
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            wb_q    <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            result  <= '0;
            flags_q <= FLAG_W'(0);
            done    <= 1'b0;
            busy    <= 1'b0;
`ifdef ALU_CTRL_IMM_EN
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_en) begin
                        rf[ld_addr] <= ld_data;
                    end
                    if (accept) begin
                        op_q  <= req.req_op;
                        rd_q  <= req.req_rd;
                        rs_q  <= req.req_rs;
                        wb_q  <= req.req_wb;
`ifdef ALU_CTRL_IMM_EN
                        imm_q     <= req.req_imm;
                        imm_sel_q <= req.req_imm_sel;
`endif
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    alu_a  <= rf[rd_q];
                    alu_b  <= src_b;
                    alu_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    result  <= alu_c;
                    flags_q <= alu_flags;
                    if (wb_q) begin
                        rf[rd_q] <= alu_c;
                    end
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: directed ops push expectations, a done-driven monitor checks them.
// Define ALU_CTRL_IMM_EN to also exercise the immediate operand path.
module tb_alu_ctrl;
    logic        clk;
    logic        reset_n;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_op;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [15:0] result;
    logic [4:0]  flags_q;
    logic        done;
    logic        busy;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_ctrl_if req_if ();

    alu_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .req       (req_if),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .alu_flags (alu_flags),
        .result    (result),
        .flags_q   (flags_q),
        .done      (done),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 05 add, 07 subtract; flags = {carry/borrow, zero, neg, 0, 0}.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (alu_op)
            8'h05:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            8'h07:   alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_sum = '0;
        endcase
        alu_c     = alu_sum[15:0];
        alu_flags = {alu_sum[16], alu_sum[15:0] == 16'h0, alu_sum[15], 2'b00};
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [4:0]  f;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [4:0] f);
        exp_t e;
        e.a = a;
        e.b = b;
        e.c = c;
        e.f = f;
        sb.push_back(e);
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                check("mon_alu_a",  32'(alu_a),   32'(e.a));
                check("mon_alu_b",  32'(alu_b),   32'(e.b));
                check("mon_result", 32'(result),  32'(e.c));
                check("mon_flags",  32'(flags_q), 32'(e.f));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [15:0] want);
        dbg_addr = a;
        #1;
        check(name, 32'(dbg_data), 32'(want));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_if.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            n_vec++;
            n_miss++;
            $display("FAIL ready_timeout: got req_ready=%b after 20 cycles, expected 1", req_if.req_ready);
        end
    endtask

    // One full operation with cycle-accurate checks; request fields are scrambled after accept.
    task automatic do_op(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic wb, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] ec, input logic [4:0] ef, input bit ld_mid);
        push_exp(ea, eb, ec, ef);
        wait_ready();
        req_if.req_op    = op;
        req_if.req_rd    = rd;
        req_if.req_rs    = rs;
        req_if.req_wb    = wb;
        req_if.req_valid = 1'b1;
        tick();
        req_if.req_valid = 1'b0;
        req_if.req_op    = 8'hFF;
        req_if.req_rd    = 4'hF;
        req_if.req_rs    = 4'hE;
        req_if.req_wb    = ~wb;
        if (ld_mid) begin
            ld_en   = 1'b1;
            ld_addr = 4'd2;
            ld_data = 16'hAAAA;
        end
        check("read_busy_ready", 32'({busy, req_if.req_ready}), 2);
        tick();
        check("exec_alu_a",  32'(alu_a),  32'(ea));
        check("exec_alu_b",  32'(alu_b),  32'(eb));
        check("exec_alu_op", 32'(alu_op), 32'(op));
        check("exec_done",   32'(done),   0);
        tick();
        ld_en = 1'b0;
        check("wb_done", 32'(done), 1);
        tick();
        check("idle_done_busy", 32'({done, busy}), 0);
        check("hold_result",    32'(result),       32'(ec));
        check("hold_alu_a",     32'(alu_a),        32'(ea));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1);
    end

    initial begin
        int t_done[$];
        reset_n          = 1'b0;
        ld_en            = 1'b0;
        ld_addr          = '0;
        ld_data          = '0;
        dbg_addr         = '0;
        req_if.req_valid = 1'b0;
        req_if.req_op    = '0;
        req_if.req_rd    = '0;
        req_if.req_rs    = '0;
        req_if.req_wb    = 1'b0;
`ifdef ALU_CTRL_IMM_EN
        req_if.req_imm     = '0;
        req_if.req_imm_sel = 1'b0;
`endif
        repeat (3) tick();
        check("rst_result", 32'(result),  0);
        check("rst_flags",  32'(flags_q), 0);
        check("rst_alu_a",  32'(alu_a),   0);
        check("rst_alu_b",  32'(alu_b),   0);
        check("rst_alu_op", 32'(alu_op),  0);
        check("rst_done_busy", 32'({done, busy}), 0);
        check("rst_ready", 32'(req_if.req_ready), 1);
        reset_n = 1'b1;
        tick();

        load(4'd1, 16'd3);
        load(4'd2, 16'd5);
        check_reg("ld_r1", 4'd1, 16'd3);
        check_reg("ld_r2", 4'd2, 16'd5);

        do_op(8'h05, 4'd1, 4'd2, 1'b1, 16'd3, 16'd5, 16'd8, 5'b00000, 1'b0);
        check_reg("wb_r1", 4'd1, 16'd8);

        load(4'd1, 16'd3);
        do_op(8'h05, 4'd1, 4'd2, 1'b0, 16'd3, 16'd5, 16'd8, 5'b00000, 1'b0);
        check_reg("nowb_r1", 4'd1, 16'd3);

        do_op(8'h07, 4'd1, 4'd2, 1'b0, 16'd3, 16'd5, 16'hFFFE, 5'b10100, 1'b1);
        check_reg("cmp_r1", 4'd1, 16'd3);
        check_reg("busy_ld_ignored_r2", 4'd2, 16'd5);

        // Load and request together: load first, accept one cycle later.
        load(4'd4, 16'd2);
        push_exp(16'hFFFF, 16'h0002, 16'h0001, 5'b10000);
        ld_en            = 1'b1;
        ld_addr          = 4'd3;
        ld_data          = 16'hFFFF;
        req_if.req_op    = 8'h05;
        req_if.req_rd    = 4'd3;
        req_if.req_rs    = 4'd4;
        req_if.req_wb    = 1'b1;
        req_if.req_valid = 1'b1;
        #1;
        check("ld_blocks_ready", 32'(req_if.req_ready), 0);
        tick();
        ld_en = 1'b0;
        check("ld_wins_not_busy", 32'(busy), 0);
        check_reg("ld_wins_r3", 4'd3, 16'hFFFF);
        tick();
        req_if.req_valid = 1'b0;
        check("late_accept_busy", 32'(busy), 1);
        repeat (3) tick();
        check_reg("carry_r3", 4'd3, 16'h0001);

        // Continuous valid: two accepts four cycles apart.
        push_exp(16'd5,  16'd5,  16'd10,   5'b00000);
        push_exp(16'd10, 16'd10, 16'h0014, 5'b00000);
        req_if.req_op    = 8'h05;
        req_if.req_rd    = 4'd2;
        req_if.req_rs    = 4'd2;
        req_if.req_wb    = 1'b1;
        req_if.req_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 5) req_if.req_valid = 1'b0;
            if (done === 1'b1) t_done.push_back(k);
            if (k == 1 || k == 2 || k == 3 || k == 5 || k == 6 || k == 7)
                check("b2b_ready_low", 32'(req_if.req_ready), 0);
            if (k == 4)
                check("b2b_ready_idle", 32'(req_if.req_ready), 1);
        end
        check("b2b_done_count", 32'(t_done.size()), 2);
        if (t_done.size() == 2) begin
            check("b2b_done0_cycle", 32'(t_done[0]), 3);
            check("b2b_done1_cycle", 32'(t_done[1]), 7);
        end
        check_reg("same_reg_r2", 4'd2, 16'h0014);

        // Reset during EXEC aborts without write-back or done.
        req_if.req_op    = 8'h05;
        req_if.req_rd    = 4'd1;
        req_if.req_rs    = 4'd2;
        req_if.req_wb    = 1'b1;
        req_if.req_valid = 1'b1;
        tick();
        req_if.req_valid = 1'b0;
        tick();
        check("pre_abort_alu_a", 32'(alu_a), 3);
        reset_n = 1'b0;
        tick();
        check("abort_done_busy", 32'({done, busy}), 0);
        check("abort_result",    32'(result),  0);
        check("abort_flags",     32'(flags_q), 0);
        check("abort_alu_a",     32'(alu_a),   0);
        check("abort_alu_b",     32'(alu_b),   0);
        check("abort_alu_op",    32'(alu_op),  0);
        reset_n = 1'b1;
        check_reg("abort_r1_cleared", 4'd1, 16'd0);
        repeat (4) tick();
        check("abort_no_late_busy", 32'(busy), 0);

`ifdef ALU_CTRL_IMM_EN
        load(4'd1, 16'd7);
        req_if.req_imm     = 16'h0009;
        req_if.req_imm_sel = 1'b1;
        do_op(8'h05, 4'd1, 4'd2, 1'b1, 16'd7, 16'd9, 16'd16, 5'b00000, 1'b0);
        req_if.req_imm_sel = 1'b0;
        check_reg("imm_r1", 4'd1, 16'd16);
`endif

        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
